// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: comparator codes, branch
// condition encodings, FSM state constants and the condition evaluator.
package branch_resolve_unit_pkg;

  localparam logic [7:0] CMP_EQ = 8'h00;
  localparam logic [7:0] CMP_GT = 8'h01;
  localparam logic [7:0] CMP_LT = 8'hFF;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_FLAGS = 2'd1;
  localparam state_t ST_RESOLVE    = 2'd2;

  function automatic logic cond_needs_flags(input logic [2:0] cond);
    return !((cond == COND_ALWAYS) || (cond == COND_NEVER));
  endfunction

  function automatic logic cond_eval(input logic [2:0] cond, input logic z,
                                     input logic g, input logic l);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_EQ:     taken = z;
      COND_NE:     taken = !z;
      COND_GT:     taken = g;
      COND_LT:     taken = l;
      COND_GE:     taken = g | z;
      COND_LE:     taken = l | z;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_flag_register.sv
// Decodes the comparator code into registered Z/G/L flags, tracks whether the
// flag register holds a legal result and pulses cmp_err on illegal codes.
module branch_resolve_unit_flag_register
  import branch_resolve_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmp_valid,
  input  logic [7:0] cmp_result,
  output logic       cmp_legal,
  output logic       flag_z,
  output logic       flag_g,
  output logic       flag_l,
  output logic       flags_valid,
  output logic       cmp_err
);

  logic code_legal;

  assign code_legal = (cmp_result == CMP_EQ) || (cmp_result == CMP_GT) ||
                      (cmp_result == CMP_LT);
  assign cmp_legal  = cmp_valid && code_legal;

  // Illegal codes match none of the three decodes, so they clear the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z      <= 1'b0;
      flag_g      <= 1'b0;
      flag_l      <= 1'b0;
      flags_valid <= 1'b0;
      cmp_err     <= 1'b0;
    end else begin
      cmp_err <= cmp_valid && !code_legal;
      if (cmp_valid) begin
        flag_z      <= (cmp_result == CMP_EQ);
        flag_g      <= (cmp_result == CMP_GT);
        flag_l      <= (cmp_result == CMP_LT);
        flags_valid <= code_legal;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches against the comparator flags, waiting (with a
// bounded timeout) when a flag-dependent branch arrives before a valid compare.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_valid,
  input  logic [7:0]        cmp_result,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ack,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              stall,
  output logic              flag_z,
  output logic              flag_g,
  output logic              flag_l,
  output logic              flags_valid,
  output logic              cmp_err,
  output logic              br_timeout
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              timeout_p1, timeout_d;
  logic [2:0]        cond_p1;
  logic [ADDR_W-1:0] target_p1;
  logic              capture;
  logic              cmp_legal;
  logic              taken;

  branch_resolve_unit_flag_register u_flag_register (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmp_valid   (cmp_valid),
    .cmp_result  (cmp_result),
    .cmp_legal   (cmp_legal),
    .flag_z      (flag_z),
    .flag_g      (flag_g),
    .flag_l      (flag_l),
    .flags_valid (flags_valid),
    .cmp_err     (cmp_err)
  );

  // A legal compare arriving with the request is used directly, so no wait.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_p1;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          capture = 1'b1;
          if (cond_needs_flags(br_cond) && !flags_valid && !cmp_legal)
            state_d = ST_WAIT_FLAGS;
          else
            state_d = ST_RESOLVE;
        end
      end
      ST_WAIT_FLAGS: begin
        cnt_d = cnt_q + 8'd1;
        if (cmp_legal) begin
          state_d = ST_RESOLVE;
        end else if (cnt_d == WAIT_MAX_C) begin
          state_d   = ST_RESOLVE;
          timeout_d = 1'b1;
        end
      end
      ST_RESOLVE: begin
        state_d   = ST_IDLE;
        cnt_d     = 8'd0;
        timeout_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = 8'd0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      timeout_p1 <= 1'b0;
      cond_p1    <= COND_NEVER;
      target_p1  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_p1 <= timeout_d;
      if (capture) begin
        cond_p1   <= br_cond;
        target_p1 <= br_target;
      end
    end
  end

  // Resolve stage: evaluated against the flag register as it stands this cycle.
  assign taken      = cond_eval(cond_p1, flag_z, flag_g, flag_l);
  assign br_ack     = (state_q == ST_RESOLVE);
  assign pc_load    = br_ack && taken && !timeout_p1;
  assign br_timeout = br_ack && timeout_p1;
  assign stall      = (state_q == ST_WAIT_FLAGS);
  assign pc_target  = target_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations per scenario.
module tb_branch_resolve_unit;

  localparam int ADDR_W   = 8;
  localparam int WAIT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmp_valid;
  logic [7:0]        cmp_result;
  logic              br_req;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              br_ack, pc_load, stall;
  logic [ADDR_W-1:0] pc_target;
  logic              flag_z, flag_g, flag_l, flags_valid, cmp_err, br_timeout;
  logic [ADDR_W+8:0] all_out;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve_unit #(.WAIT_MAX(WAIT_MAX), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmp_valid   (cmp_valid),
    .cmp_result  (cmp_result),
    .br_req      (br_req),
    .br_cond     (br_cond),
    .br_target   (br_target),
    .br_ack      (br_ack),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .stall       (stall),
    .flag_z      (flag_z),
    .flag_g      (flag_g),
    .flag_l      (flag_l),
    .flags_valid (flags_valid),
    .cmp_err     (cmp_err),
    .br_timeout  (br_timeout)
  );

  always #5 clk = ~clk;

  assign all_out = {br_ack, pc_load, pc_target, stall, flag_z, flag_g, flag_l,
                    flags_valid, cmp_err, br_timeout};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmp_valid = 1'b0; cmp_result = 8'h00;
    br_req = 1'b0; br_cond = 3'd0; br_target = '0;
    step(); step();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL after_reset_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_gt_taken();
    cmp_valid = 1'b1; cmp_result = 8'h01;
    step();
    cmp_valid = 1'b0;
    n_cmp++;
    if ({flag_g, flag_z, flag_l, flags_valid} !== 4'b1001) begin
      n_bad++; $display("FAIL gt_flags: got gzlv=%b want 1001", {flag_g, flag_z, flag_l, flags_valid});
    end
    br_req = 1'b1; br_cond = 3'd2; br_target = 8'h3C;
    step();
    br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, stall, br_timeout} !== 4'b1100) begin
      n_bad++; $display("FAIL gt_resolve: got ack/load/stall/to=%b want 1100", {br_ack, pc_load, stall, br_timeout});
    end
    n_cmp++;
    if (pc_target !== 8'h3C) begin
      n_bad++; $display("FAIL gt_target: got %h want 3c", pc_target);
    end
    step();
    n_cmp++;
    if ({br_ack, pc_load} !== 2'b00) begin
      n_bad++; $display("FAIL gt_ack_pulse: got ack/load=%b want 00", {br_ack, pc_load});
    end
  endtask

  task automatic test_ne_le();
    cmp_valid = 1'b1; cmp_result = 8'h00;
    step();
    cmp_valid = 1'b0;
    n_cmp++;
    if ({flag_z, flag_g, flag_l} !== 3'b100) begin
      n_bad++; $display("FAIL z_flags: got zgl=%b want 100", {flag_z, flag_g, flag_l});
    end
    br_req = 1'b1; br_cond = 3'd1; br_target = 8'h10;
    step();
    br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load} !== 2'b10) begin
      n_bad++; $display("FAIL ne_not_taken: got ack/load=%b want 10", {br_ack, pc_load});
    end
    step();
    br_req = 1'b1; br_cond = 3'd5; br_target = 8'h44;
    step();
    br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, pc_target} !== {2'b11, 8'h44}) begin
      n_bad++; $display("FAIL le_taken: got ack/load/tgt=%h want 344", {br_ack, pc_load, pc_target});
    end
    step();
  endtask

  task automatic test_wait_resolve();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    br_req = 1'b1; br_cond = 3'd3; br_target = 8'h22;
    step();
    n_cmp++;
    if ({stall, br_ack} !== 2'b10) begin
      n_bad++; $display("FAIL lt_wait_c1: got stall/ack=%b want 10", {stall, br_ack});
    end
    step();
    step();
    n_cmp++;
    if ({stall, br_ack} !== 2'b10) begin
      n_bad++; $display("FAIL lt_wait_c3: got stall/ack=%b want 10", {stall, br_ack});
    end
    cmp_valid = 1'b1; cmp_result = 8'hFF;
    step();
    cmp_valid = 1'b0; br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, stall, br_timeout, flag_l} !== 5'b11001) begin
      n_bad++; $display("FAIL lt_resolve: got ack/load/stall/to/l=%b want 11001", {br_ack, pc_load, stall, br_timeout, flag_l});
    end
    n_cmp++;
    if (pc_target !== 8'h22) begin
      n_bad++; $display("FAIL lt_target: got %h want 22", pc_target);
    end
    step();
  endtask

  task automatic test_timeout();
    int stall_cycles;
    cmp_valid = 1'b1; cmp_result = 8'h05;
    step();
    cmp_valid = 1'b0;
    n_cmp++;
    if ({cmp_err, flags_valid, flag_z, flag_g, flag_l} !== 5'b10000) begin
      n_bad++; $display("FAIL illegal_code: got err/v/z/g/l=%b want 10000", {cmp_err, flags_valid, flag_z, flag_g, flag_l});
    end
    step();
    n_cmp++;
    if (cmp_err !== 1'b0) begin
      n_bad++; $display("FAIL cmp_err_pulse: got %b want 0", cmp_err);
    end
    br_req = 1'b1; br_cond = 3'd0; br_target = 8'h55;
    step();
    stall_cycles = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      if (i == 6) begin
        cmp_valid = 1'b0;
        n_cmp++;
        if (cmp_err !== 1'b1) begin
          n_bad++; $display("FAIL wait_illegal_err: got %b want 1", cmp_err);
        end
      end
      if (br_ack) begin
        n_cmp++; n_bad++; $display("FAIL early_ack: got ack at wait cycle %0d want none", i);
      end
      stall_cycles++;
      if (i == 5) begin
        cmp_valid = 1'b1; cmp_result = 8'h7E;
      end
      step();
    end
    br_req = 1'b0;
    n_cmp++;
    if (stall_cycles != WAIT_MAX) begin
      n_bad++; $display("FAIL timeout_stall_len: got %0d want %0d", stall_cycles, WAIT_MAX);
    end
    n_cmp++;
    if ({br_ack, br_timeout, pc_load, stall} !== 4'b1100) begin
      n_bad++; $display("FAIL timeout_resolve: got ack/to/load/stall=%b want 1100", {br_ack, br_timeout, pc_load, stall});
    end
    step();
    n_cmp++;
    if ({br_ack, br_timeout} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_pulse: got ack/to=%b want 00", {br_ack, br_timeout});
    end
  endtask

  task automatic test_always_never();
    br_req = 1'b1; br_cond = 3'd6; br_target = 8'h80;
    step();
    br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, stall, pc_target} !== {3'b110, 8'h80}) begin
      n_bad++; $display("FAIL always_taken: got ack/load/stall/tgt=%h want 680", {br_ack, pc_load, stall, pc_target});
    end
    step();
    br_req = 1'b1; br_cond = 3'd7; br_target = 8'h90;
    step();
    br_req = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, stall} !== 3'b100) begin
      n_bad++; $display("FAIL never_ack_only: got ack/load/stall=%b want 100", {br_ack, pc_load, stall});
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    br_req = 1'b1; br_cond = 3'd2; br_target = 8'h33;
    step(); step(); step(); step();
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL mid_wait_stall: got %b want 1", stall);
    end
    rst_n = 1'b0; br_req = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", all_out);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({br_ack, stall} !== 2'b00) begin
      n_bad++; $display("FAIL abandoned_req: got ack/stall=%b want 00", {br_ack, stall});
    end
    br_req = 1'b1; br_cond = 3'd4; br_target = 8'h66;
    cmp_valid = 1'b1; cmp_result = 8'h01;
    step();
    br_req = 1'b0; cmp_valid = 1'b0;
    n_cmp++;
    if ({br_ack, pc_load, stall, pc_target} !== {3'b110, 8'h66}) begin
      n_bad++; $display("FAIL coincident_cmp: got ack/load/stall/tgt=%h want 666", {br_ack, pc_load, stall, pc_target});
    end
    step();
  endtask

  task automatic test_back_to_back();
    br_req = 1'b1; br_cond = 3'd0; br_target = 8'h11;
    step();
    n_cmp++;
    if ({br_ack, pc_load} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_first: got ack/load=%b want 10", {br_ack, pc_load});
    end
    br_cond = 3'd2; br_target = 8'h22;
    step();
    n_cmp++;
    if (br_ack !== 1'b0) begin
      n_bad++; $display("FAIL b2b_ignored_in_resolve: got ack=%b want 0", br_ack);
    end
    step();
    br_req = 1'b0;
    cmp_valid = 1'b1; cmp_result = 8'h00;
    n_cmp++;
    if ({br_ack, pc_load, pc_target} !== {2'b11, 8'h22}) begin
      n_bad++; $display("FAIL b2b_second: got ack/load/tgt=%h want 322", {br_ack, pc_load, pc_target});
    end
    step();
    cmp_valid = 1'b0;
    n_cmp++;
    if ({flag_z, flag_g, br_ack} !== 3'b100) begin
      n_bad++; $display("FAIL resolve_cmp_update: got z/g/ack=%b want 100", {flag_z, flag_g, br_ack});
    end
  endtask

  initial begin
    test_reset();
    test_gt_taken();
    test_ne_le();
    test_wait_resolve();
    test_timeout();
    test_always_never();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits directly downstream of the 8-bit magnitude comparator and consumes its 8-bit result code.
- Code meanings: 0x00 = equal, 0x01 = A>B, 0xFF = A<B.
- Latches the result into a Z/G/L flag register, then resolves conditional-branch requests from the control unit.
- Drives the PC load strobe and target, with a wait/timeout state machine for branches issued before a valid compare.

Parameters:
- WAIT_MAX, 15, max cycles spent in WAIT_FLAGS before a not-taken timeout (1..255).
- ADDR_W, 8, width of branch target and PC target.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmp_valid  in  1  comparator result valid this cycle
- cmp_result  in  8  comparator code (0x00/0x01/0xFF legal)
- br_req  in  1  branch request; held with br_cond/br_target until br_ack
- br_cond  in  3  0 EQ, 1 NE, 2 GT, 3 LT, 4 GE, 5 LE, 6 ALWAYS, 7 NEVER
- br_target  in  ADDR_W  branch destination
- br_ack  out  1  one-cycle pulse: request resolved
- pc_load  out  1  one-cycle pulse, coincident with br_ack, when taken
- pc_target  out  ADDR_W  registered target, meaningful when pc_load=1
- stall  out  1  high while in WAIT_FLAGS
- flag_z, flag_g, flag_l  out  1 each  registered flags
- flags_valid  out  1  flag register holds a legal result
- cmp_err  out  1  one-cycle pulse: illegal cmp_result seen with cmp_valid
- br_timeout  out  1  one-cycle pulse with br_ack when WAIT_MAX expired

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, wait counter=0. Reset mid-wait abandons the request with no br_ack.
- Flag register on cmp_valid:
  - 0x00 -> Z=1, G=0, L=0.
  - 0x01 -> G=1, Z=0, L=0.
  - 0xFF -> L=1, Z=0, G=0.
  - For all three legal codes, flags_valid=1 next cycle.
  - Any other value -> flags cleared, flags_valid=0, cmp_err pulses next cycle.
  - Flags persist until the next cmp_valid; a branch does not consume them.
- Conditions:
  - EQ=Z, NE=!Z, GT=G, LT=L, GE=G|Z, LE=L|Z.
  - ALWAYS=1 and NEVER=0; both are flag-independent.
- FSM IDLE:
  - On br_req, capture cond and target.
  - Go to WAIT_FLAGS if the cond needs flags and flags_valid=0 and no legal cmp_valid is present this cycle.
  - Otherwise go to RESOLVE.
- FSM WAIT_FLAGS:
  - stall=1; counter increments each cycle.
  - Legal cmp_valid -> RESOLVE.
  - Illegal cmp_valid -> stay (cmp_err pulses).
  - Counter reaching WAIT_MAX -> RESOLVE with timeout flag set.
- FSM RESOLVE (one cycle):
  - Evaluate the captured cond against the current flag register.
  - br_ack=1; pc_load=taken & !timeout; pc_target=captured target; br_timeout=timeout.
  - Clear counter, return to IDLE.
- Latency: request with flags already valid -> br_ack exactly 1 cycle after capture.
- br_req sampled high during the RESOLVE cycle is ignored; it is re-sampled in IDLE the following cycle. Minimum issue interval is 2 cycles.
- A cmp_valid in the RESOLVE cycle updates flags for later branches only.
- cmp_valid coincident with the IDLE capture: the new flags are the ones used.

Decomposition:
- Shared cpu package holds:
  - comparator code constants CMP_EQ=8'h00, CMP_GT=8'h01, CMP_LT=8'hFF;
  - br_cond encodings;
  - FSM state enum (IDLE, WAIT_FLAGS, RESOLVE).
- One natural sub-module: flag_register (decode, flags_valid, cmp_err). The FSM, counter and condition evaluation stay in the top.

Test Plan:
- cmp_valid with 0x01, then br_req GT target 0x3C -> 1 cycle later br_ack=1, pc_load=1, pc_target=0x3C, flag_g=1.
- Flags Z=1, br_req NE target 0x10 -> br_ack=1, pc_load=0; br_req LE -> pc_load=1.
- Reset, br_req LT target 0x22 -> stall=1; cmp 0xFF on wait cycle 3 -> RESOLVE next cycle, pc_load=1, stall drops.
- cmp_valid with 0x05 -> cmp_err pulse, flags_valid=0; br_req EQ -> stall for WAIT_MAX=15 cycles, then br_ack=1, br_timeout=1, pc_load=0.
- No flags, br_req ALWAYS target 0x80 -> no stall, pc_load=1 one cycle later; NEVER -> br_ack only.
- rst_n low during WAIT_FLAGS cycle 4 -> all outputs 0 immediately, no br_ack; a new request after reset behaves normally.
